// File: rtl/hv_cmd_scheduler.sv
// hv_cmd_scheduler: arbitrates HV module commands (HON/HOF, HBVdddd set-voltage,
// optional HGV monitor) onto a single byte channel. One command is in flight at
// a time: frame is serialised, the reply is awaited, timeouts trigger re-sends and
// an exhausted retry budget raises a sticky error flag.
// Optional feature: define HV_AUTO_MON_EN to add the periodic HGV monitor request.
module hv_cmd_scheduler #(
    parameter int TIMEOUT_CYC = 4_000_000,
    parameter int GAP_CYC     = 400,
`ifdef HV_AUTO_MON_EN
    parameter int MON_PERIOD  = 40_000_000,
`endif
    parameter int MAX_RETRY   = 2
) (
    input  logic        Clk_In,
    input  logic        Rst_N,
    input  logic        Req_Cfg,
    input  logic [55:0] In_Hv_7Byte,
    input  logic        Req_Start_Stop,
    input  logic        In_Flag_Start,
    output logic [7:0]  Out_Byte,
    output logic        Out_Byte_Valid,
    input  logic        In_Byte_Ready,
    input  logic        In_Rx_Done,
    output logic        Out_Busy,
    output logic [1:0]  Out_Cur_Cmd,
    output logic        Out_Hv_On,
    output logic        Out_Err
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_ONOFF = 2'd1;
    localparam logic [1:0] CMD_CFG   = 2'd2;
    localparam logic [1:0] CMD_MON   = 2'd3;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_N  = 8'h4E;
    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_G  = 8'h47;
    localparam logic [7:0] CH_V  = 8'h56;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_RSP,
        ST_GAP
    } state_t;

    state_t state;
    state_t state_next;

    // pending latches, one per requester class
    logic        pend_onoff;
    logic        pend_cfg;
    logic        pend_mon;
    logic        lat_flag;
    logic [55:0] lat_cfg;

    // frame in flight
    logic [7:0]  frame [8];
    logic [2:0]  byte_idx;
    logic [2:0]  last_idx;
    logic        cur_flag;
    logic [1:0]  cur_cmd;

    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic             hv_on;
    logic             err;

    // FSM strobes
    logic grant;
    logic ack;
    logic retry_go;
    logic give_up;

    logic sel_onoff;
    logic sel_cfg;
    logic sel_mon;
    logic tmo_last;
    logic gap_last;
    logic byte_last;

    // fixed priority: on/off > cfg > monitor
    assign sel_onoff = pend_onoff;
    assign sel_cfg   = ~pend_onoff & pend_cfg;
    assign sel_mon   = ~pend_onoff & ~pend_cfg & pend_mon;

    assign tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));
    assign byte_last = (byte_idx == last_idx);

    assign Out_Byte_Valid = (state == ST_SEND);
    assign Out_Byte       = (state == ST_SEND) ? frame[byte_idx] : 8'h00;
    assign Out_Busy       = (state != ST_IDLE);
    assign Out_Cur_Cmd    = cur_cmd;
    assign Out_Hv_On      = hv_on;
    assign Out_Err        = err;

    // state register; async reset drops Valid immediately and aborts any frame
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode and single-cycle control strobes
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        ack        = 1'b0;
        retry_go   = 1'b0;
        give_up    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_onoff || pend_cfg || pend_mon) begin
                    grant      = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (In_Byte_Ready && byte_last) begin
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // a reply arriving in the timeout cycle still counts as an ack
                if (In_Rx_Done) begin
                    ack        = 1'b1;
                    state_next = ST_GAP;
                end else if (tmo_last) begin
                    if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        retry_go   = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        give_up    = 1'b1;
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // request latches: a new pulse always wins over the grant clear so a
    // same-cycle or same-class request is re-pended rather than lost
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            pend_onoff <= 1'b0;
            pend_cfg   <= 1'b0;
            lat_flag   <= 1'b0;
            lat_cfg    <= '0;
        end else begin
            if (Req_Start_Stop) begin
                pend_onoff <= 1'b1;
                lat_flag   <= In_Flag_Start;
            end else if (grant && sel_onoff) begin
                pend_onoff <= 1'b0;
            end
            if (Req_Cfg) begin
                pend_cfg <= 1'b1;
                lat_cfg  <= In_Hv_7Byte;
            end else if (grant && sel_cfg) begin
                pend_cfg <= 1'b0;
            end
        end
    end

`ifdef HV_AUTO_MON_EN
    localparam int MON_W = (MON_PERIOD > 1) ? $clog2(MON_PERIOD) : 1;

    logic [MON_W-1:0] mon_cnt;
    logic             mon_wrap;

    assign mon_wrap = (mon_cnt == MON_W'(MON_PERIOD - 1));

    // free-running monitor period counter; keeps counting while busy
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            mon_cnt  <= '0;
            pend_mon <= 1'b0;
        end else begin
            mon_cnt <= mon_wrap ? '0 : mon_cnt + 1'b1;
            if (mon_wrap) begin
                pend_mon <= 1'b1;
            end else if (grant && sel_mon) begin
                pend_mon <= 1'b0;
            end
        end
    end
`else
    assign pend_mon = 1'b0;
`endif

    // frame build on grant; retries reuse the stored frame untouched
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            for (int i = 0; i < 8; i++) begin
                frame[i] <= 8'h00;
            end
            last_idx <= 3'd0;
            cur_flag <= 1'b0;
        end else if (grant) begin
            if (sel_onoff) begin
                frame[0] <= CH_H;
                frame[1] <= CH_O;
                frame[2] <= lat_flag ? CH_N : CH_F;
                frame[3] <= CH_CR;
                for (int i = 4; i < 8; i++) begin
                    frame[i] <= 8'h00;
                end
                last_idx <= 3'd3;
                cur_flag <= lat_flag;
            end else if (sel_cfg) begin
                for (int i = 0; i < 7; i++) begin
                    frame[i] <= lat_cfg[55 - 8*i -: 8];
                end
                frame[7] <= CH_CR;
                last_idx <= 3'd7;
            end else if (sel_mon) begin
                frame[0] <= CH_H;
                frame[1] <= CH_G;
                frame[2] <= CH_V;
                frame[3] <= CH_CR;
                for (int i = 4; i < 8; i++) begin
                    frame[i] <= 8'h00;
                end
                last_idx <= 3'd3;
            end
        end
    end

    // active class: set on grant, cleared when the post-reply gap ends
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            cur_cmd <= CMD_NONE;
        end else if (grant) begin
            if (sel_onoff) begin
                cur_cmd <= CMD_ONOFF;
            end else if (sel_cfg) begin
                cur_cmd <= CMD_CFG;
            end else begin
                cur_cmd <= CMD_MON;
            end
        end else if (state == ST_GAP && gap_last) begin
            cur_cmd <= CMD_NONE;
        end
    end

    // byte pointer: rewinds in LOAD, advances on each accepted byte, never wraps
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            byte_idx <= 3'd0;
        end else if (state == ST_LOAD) begin
            byte_idx <= 3'd0;
        end else if (state == ST_SEND && In_Byte_Ready && !byte_last) begin
            byte_idx <= byte_idx + 3'd1;
        end
    end

    // reply timeout and inter-frame gap timers, held at zero outside their state
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == ST_WAIT_RSP && !tmo_last) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (state == ST_GAP && !gap_last) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // retry counter, HV state and sticky error
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            retry_cnt <= '0;
            hv_on     <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (grant) begin
                retry_cnt <= '0;
            end else if (retry_go) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (ack && cur_cmd == CMD_ONOFF) begin
                hv_on <= cur_flag;
            end
            // a give-up in the same cycle as a new request keeps the flag raised
            if (give_up) begin
                err <= 1'b1;
            end else if (Req_Cfg || Req_Start_Stop) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hv_cmd_scheduler.sv
// Testbench for hv_cmd_scheduler: expected frame bytes are queued when a request
// is issued; a monitor pops and compares every byte the DUT hands over.
// Build with HV_AUTO_MON_EN defined to exercise the periodic monitor frames.
`timescale 1ns/1ps
module tb_hv_cmd_scheduler;

    localparam int TMO = 100;
    localparam int GAP = 40;
    localparam int RTY = 2;

    logic        Clk_In = 1'b0;
    logic        Rst_N = 1'b1;
    logic        Req_Cfg = 1'b0;
    logic [55:0] In_Hv_7Byte = '0;
    logic        Req_Start_Stop = 1'b0;
    logic        In_Flag_Start = 1'b0;
    logic [7:0]  Out_Byte;
    logic        Out_Byte_Valid;
    logic        In_Byte_Ready = 1'b0;
    logic        In_Rx_Done = 1'b0;
    logic        Out_Busy;
    logic [1:0]  Out_Cur_Cmd;
    logic        Out_Hv_On;
    logic        Out_Err;

    int checks = 0;
    int errors = 0;
    int bytes_seen = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [7:0] exp_q[$];

    hv_cmd_scheduler #(
        .TIMEOUT_CYC(TMO),
        .GAP_CYC(GAP),
`ifdef HV_AUTO_MON_EN
        .MON_PERIOD(1000),
`endif
        .MAX_RETRY(RTY)
    ) dut (
        .Clk_In(Clk_In),
        .Rst_N(Rst_N),
        .Req_Cfg(Req_Cfg),
        .In_Hv_7Byte(In_Hv_7Byte),
        .Req_Start_Stop(Req_Start_Stop),
        .In_Flag_Start(In_Flag_Start),
        .Out_Byte(Out_Byte),
        .Out_Byte_Valid(Out_Byte_Valid),
        .In_Byte_Ready(In_Byte_Ready),
        .In_Rx_Done(In_Rx_Done),
        .Out_Busy(Out_Busy),
        .Out_Cur_Cmd(Out_Cur_Cmd),
        .Out_Hv_On(Out_Hv_On),
        .Out_Err(Out_Err)
    );

    always #12.5 Clk_In = ~Clk_In;

    always @(posedge Clk_In) cyc <= cyc + 1;

    // ready driver: mode 0 always ready, mode 1 ready one cycle in three
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge Clk_In);
            #1;
            ph = (ph + 1) % 3;
            In_Byte_Ready = (ready_mode == 0) ? 1'b1 : (ph == 0);
        end
    end

    // monitor: byte order against the scoreboard and hold-until-accepted
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pb;
        logic [7:0] e;
        pv = 1'b0;
        pr = 1'b0;
        pb = 8'h00;
        forever begin
            @(negedge Clk_In);
            if (Rst_N) begin
                if (pv && !pr) begin
                    checks++;
                    if (!Out_Byte_Valid || Out_Byte !== pb) begin
                        errors++;
                        $display("FAIL hold: valid=%0b byte=%02h required valid=1 byte=%02h",
                                 Out_Byte_Valid, Out_Byte, pb);
                    end
                end
                if (Out_Byte_Valid && In_Byte_Ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL byte_unexpected: got %02h required none", Out_Byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (Out_Byte !== e) begin
                            errors++;
                            $display("FAIL byte[%0d]: got %02h required %02h", bytes_seen, Out_Byte, e);
                        end
                    end
                    bytes_seen++;
                end
                pv = Out_Byte_Valid;
                pr = In_Byte_Ready;
                pb = Out_Byte;
            end else begin
                pv = 1'b0;
                pr = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk_In);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(f[63 - 8*i -: 8]);
        end
    endtask

    task automatic wait_bytes(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (bytes_seen < n && k < limit) begin
            tick(1);
            k++;
        end
        if (bytes_seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s: bytes %0d required %0d within %0d cycles", name, bytes_seen, n, limit);
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k;
        k = 0;
        while (Out_Busy && k < limit) begin
            tick(1);
            k++;
        end
        if (Out_Busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy=1 required 0 within %0d cycles", name, limit);
        end
    endtask

    task automatic rx_pulse();
        In_Rx_Done = 1'b1;
        tick(1);
        In_Rx_Done = 1'b0;
    endtask

    task automatic req_onoff(input logic flag);
        In_Flag_Start  = flag;
        Req_Start_Stop = 1'b1;
        tick(1);
        Req_Start_Stop = 1'b0;
    endtask

    task automatic req_cfg(input logic [55:0] d);
        In_Hv_7Byte = d;
        Req_Cfg     = 1'b1;
        tick(1);
        Req_Cfg     = 1'b0;
    endtask

    initial begin
        int t1;
        int t_prev;
        #2 Rst_N = 1'b0;
        #200;
        chk("rst_valid", Out_Byte_Valid, 0);
        chk("rst_byte", Out_Byte, 0);
        chk("rst_busy", Out_Busy, 0);
        chk("rst_cmd", Out_Cur_Cmd, 0);
        chk("rst_hv_on", Out_Hv_On, 0);
        chk("rst_err", Out_Err, 0);
        @(posedge Clk_In);
        #1;
        Rst_N = 1'b1;

`ifdef HV_AUTO_MON_EN
        ready_mode = 0;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            push_frame({8'h48, 8'h47, 8'h56, 8'h0D, 32'h0}, 4);
            wait_bytes(4*i + 1, 1200, "mon_start");
            if (i > 0) chk("mon_period", cyc - t_prev, 1000);
            t_prev = cyc;
            wait_bytes(4*i + 4, 20, "mon_frame");
            chk("mon_cmd", Out_Cur_Cmd, 3);
            tick(3);
            rx_pulse();
            wait_idle(GAP + 10, "mon_idle");
            chk("mon_hv_on", Out_Hv_On, 0);
            chk("mon_err", Out_Err, 0);
        end
`else
        // idle: no frames without requests
        tick(1000);
        chk("idle_bytes", bytes_seen, 0);
        chk("idle_busy", Out_Busy, 0);

        // set-voltage frame with slow ready; latency and gap timing
        ready_mode = 1;
        push_frame({56'h48_42_56_31_32_33_34, 8'h0D}, 8);
        req_cfg(56'h48_42_56_31_32_33_34);
        chk("lat_n1_valid", Out_Byte_Valid, 0);
        chk("lat_n1_busy", Out_Busy, 0);
        tick(1);
        chk("lat_n2_valid", Out_Byte_Valid, 0);
        chk("lat_n2_busy", Out_Busy, 1);
        chk("cfg_cmd", Out_Cur_Cmd, 2);
        tick(1);
        chk("lat_n3_valid", Out_Byte_Valid, 1);
        chk("cfg_byte0", Out_Byte, 8'h48);
        wait_bytes(8, 100, "cfg_frame");
        tick(49);
        rx_pulse();
        tick(GAP - 1);
        chk("gap_busy_end", Out_Busy, 1);
        tick(1);
        chk("gap_busy_low", Out_Busy, 0);
        chk("gap_cmd_none", Out_Cur_Cmd, 0);
        chk("cfg_hv_on", Out_Hv_On, 0);

        // simultaneous requests: on/off wins
        ready_mode = 0;
        push_frame({8'h48, 8'h4F, 8'h4E, 8'h0D, 32'h0}, 4);
        push_frame({56'h48_42_56_30_35_36_37, 8'h0D}, 8);
        In_Hv_7Byte    = 56'h48_42_56_30_35_36_37;
        In_Flag_Start  = 1'b1;
        Req_Cfg        = 1'b1;
        Req_Start_Stop = 1'b1;
        tick(1);
        Req_Cfg        = 1'b0;
        Req_Start_Stop = 1'b0;
        wait_bytes(12, 50, "prio_on_frame");
        tick(5);
        chk("prio_cmd_on", Out_Cur_Cmd, 1);
        rx_pulse();
        chk("prio_hv_on", Out_Hv_On, 1);
        wait_bytes(20, 200, "prio_cfg_frame");
        tick(5);
        chk("prio_cmd_cfg", Out_Cur_Cmd, 2);
        rx_pulse();
        wait_idle(GAP + 10, "prio_idle");

        // HOF with a stray reply mid-SEND
        ready_mode = 1;
        push_frame({8'h48, 8'h4F, 8'h46, 8'h0D, 32'h0}, 4);
        req_onoff(1'b0);
        wait_bytes(22, 50, "off_half");
        rx_pulse();
        chk("off_midsend_hv", Out_Hv_On, 1);
        wait_bytes(24, 50, "off_frame");
        chk("off_wait_hv", Out_Hv_On, 1);
        chk("off_cmd", Out_Cur_Cmd, 1);
        tick(3);
        rx_pulse();
        chk("off_hv_off", Out_Hv_On, 0);
        wait_idle(GAP + 10, "off_idle");

        // no reply: three attempts then error
        ready_mode = 0;
        for (int i = 0; i < 3; i++) push_frame({56'h48_42_56_32_35_30_30, 8'h0D}, 8);
        req_cfg(56'h48_42_56_32_35_30_30);
        wait_bytes(32, 50, "tmo_frame1");
        t1 = cyc;
        wait_bytes(33, 200, "tmo_frame2_start");
        chk("tmo_resend_spacing", cyc - t1, TMO + 2);
        wait_bytes(48, 400, "tmo_frame3");
        chk("tmo_err_pre", Out_Err, 0);
        tick(TMO - 1);
        chk("tmo_err_last", Out_Err, 0);
        chk("tmo_busy", Out_Busy, 1);
        tick(1);
        chk("tmo_err_set", Out_Err, 1);
        wait_idle(GAP + 10, "tmo_idle");
        chk("tmo_err_sticky", Out_Err, 1);
        chk("tmo_bytes", bytes_seen, 48);
        rx_pulse();
        chk("idle_rx_hv", Out_Hv_On, 0);
        chk("idle_rx_busy", Out_Busy, 0);
        push_frame({8'h48, 8'h4F, 8'h4E, 8'h0D, 32'h0}, 4);
        req_onoff(1'b1);
        chk("err_cleared", Out_Err, 0);
        wait_bytes(52, 50, "on2_frame");
        tick(2);
        rx_pulse();
        chk("on2_hv_on", Out_Hv_On, 1);
        wait_idle(GAP + 10, "on2_idle");

        // no monitor class in this build
        tick(5000);
        chk("no_mon_bytes", bytes_seen, 52);
        chk("no_mon_cmd", Out_Cur_Cmd, 0);
`endif
        tick(20);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
